// File: rtl/parsing_pkg.sv
// Shared constants, loader state encoding and width helper for the parsing datapath.
package parsing_pkg;

  localparam int NUM_BANK       = 16;
  localparam int DATA_W         = 128;
  localparam int ADDR_W         = 9;
  localparam int WORDS_PER_BANK = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    GAP   = 2'd2,
    START = 2'd3
  } loader_state_e;

  // Ceiling log2, floored at 1 so degenerate counters keep a legal width.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end else begin
      result = result;
    end
    return result;
  endfunction

endpackage

// File: rtl/bram_addr_gen.sv
// Nested word/bank counter: the word counter wraps per bank and carries into the bank counter.
module bram_addr_gen #(
  parameter int NB  = 16,
  parameter int WPB = 128
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               clr,
  input  logic                               inc,
  output logic [parsing_pkg::clog2(NB)-1:0]  bank,
  output logic [parsing_pkg::clog2(WPB)-1:0] word,
  output logic                               last_word,
  output logic                               last
);
  import parsing_pkg::*;

  localparam int BANK_W = clog2(NB);
  localparam int WORD_W = clog2(WPB);

  logic [BANK_W-1:0] bank_r;
  logic [WORD_W-1:0] word_r;

  // Word counter wraps naturally since WPB is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_r <= '0;
      word_r <= '0;
    end else if (clr) begin
      bank_r <= '0;
      word_r <= '0;
    end else if (inc) begin
      word_r <= word_r + WORD_W'(1);
      if (last_word) begin
        bank_r <= bank_r + BANK_W'(1);
      end
    end
  end

  assign bank      = bank_r;
  assign word      = word_r;
  assign last_word = (word_r == WORD_W'(WPB - 1));
  assign last      = last_word && (bank_r == BANK_W'(NB - 1));

endmodule

// File: rtl/bram_bank_loader.sv
// Streams feature-map words into the input BRAM banks in order, then pulses oStart after a settle gap.
module bram_bank_loader #(
  parameter int NUM_BANK       = parsing_pkg::NUM_BANK,
  parameter int DATA_W         = parsing_pkg::DATA_W,
  parameter int ADDR_W         = parsing_pkg::ADDR_W,
  parameter int WORDS_PER_BANK = parsing_pkg::WORDS_PER_BANK,
  parameter int START_GAP      = 10
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                iLoad,
  input  logic                iValid,
  input  logic [DATA_W-1:0]   iData,
  output logic                oReady,
  output logic [NUM_BANK-1:0] o_ena,
  output logic [NUM_BANK-1:0] o_wea,
  output logic [ADDR_W-1:0]   o_addra,
  output logic [DATA_W-1:0]   o_dia,
  output logic                oStart,
  output logic                oBusy,
  output logic                oDone
);
  import parsing_pkg::*;

  localparam int BANK_W = clog2(NUM_BANK);
  localparam int WORD_W = clog2(WORDS_PER_BANK);
  localparam int GAP_W  = clog2(START_GAP + 1);

  loader_state_e     state_r, state_next_s;
  logic [GAP_W-1:0]  gap_r, gap_next_s;
  logic [BANK_W-1:0] bank_s;
  logic [WORD_W-1:0] word_s;
  logic              last_word_s, last_s;
  logic              accept_s, clr_s;

  assign accept_s = iValid && oReady;
  assign clr_s    = (state_r == IDLE) && iLoad;

  bram_addr_gen #(
    .NB  (NUM_BANK),
    .WPB (WORDS_PER_BANK)
  ) u_addr_gen (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (clr_s),
    .inc       (accept_s),
    .bank      (bank_s),
    .word      (word_s),
    .last_word (last_word_s),
    .last      (last_s)
  );

  // Next-state and gap countdown; START is entered one cycle after the gap counter drains.
  always_comb begin
    state_next_s = state_r;
    gap_next_s   = gap_r;
    case (state_r)
      IDLE: begin
        if (iLoad) state_next_s = LOAD;
        else       state_next_s = IDLE;
      end
      LOAD: begin
        if (accept_s && last_s) begin
          state_next_s = GAP;
          gap_next_s   = GAP_W'(START_GAP);
        end else begin
          state_next_s = LOAD;
        end
      end
      GAP: begin
        if (gap_r == '0) state_next_s = START;
        else             gap_next_s   = gap_r - GAP_W'(1);
      end
      START:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, gap counter and status outputs, all decoded from the next state so they stay registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      gap_r   <= '0;
      oReady  <= 1'b0;
      oBusy   <= 1'b0;
      oStart  <= 1'b0;
      oDone   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      gap_r   <= gap_next_s;
      oReady  <= (state_next_s == LOAD);
      oBusy   <= (state_next_s != IDLE);
      oStart  <= (state_next_s == START);
      if (clr_s)                 oDone <= 1'b0;
      else if (state_r == START) oDone <= 1'b1;
    end
  end

  // Registered write port: strobe only for the cycle after an accept, address/data hold otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_ena   <= '0;
      o_wea   <= '0;
      o_addra <= '0;
      o_dia   <= '0;
    end else if (accept_s) begin
      o_ena   <= NUM_BANK'(1) << bank_s;
      o_wea   <= NUM_BANK'(1) << bank_s;
      o_addra <= ADDR_W'(word_s);
      o_dia   <= iData;
    end else begin
      o_ena   <= '0;
      o_wea   <= '0;
    end
  end

endmodule

// File: tb/tb_bram_bank_loader.sv
// Scoreboard bench for bram_bank_loader: a cycle model predicts status and queues each expected write strobe.
module tb_bram_bank_loader;

  localparam int NB   = 16;
  localparam int WPB  = 128;
  localparam int GAPC = 10;

  typedef struct packed {
    logic [15:0]  ena;
    logic [8:0]   addr;
    logic [127:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic         iLoad, iValid;
  logic [127:0] iData;
  logic         oReady, oStart, oBusy, oDone;
  logic [15:0]  o_ena, o_wea;
  logic [8:0]   o_addra;
  logic [127:0] o_dia;

  wr_t exp_q[$];
  int  n_cmp = 0, n_bad = 0;
  int  m_st, m_gap, m_bank, m_word;
  logic m_done;
  int  edge_idx = 0, last_acc_edge = 0, start_edge = 0, start_cnt = 0, strobe_cnt = 0;

  bram_bank_loader dut (
    .clk(clk), .rstn(rstn), .iLoad(iLoad), .iValid(iValid), .iData(iData),
    .oReady(oReady), .o_ena(o_ena), .o_wea(o_wea), .o_addra(o_addra), .o_dia(o_dia),
    .oStart(oStart), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_st = 0; m_gap = 0; m_bank = 0; m_word = 0; m_done = 1'b0;
    exp_q.delete();
  endtask

  // One clock: drive at negedge, advance model, check at the following negedge.
  task automatic step(input logic v, input logic ld);
    logic acc;
    wr_t  w, got;
    iValid = v;
    iLoad  = ld;
    iData  = v ? {8{8'(m_bank), 8'(m_word)}} : {4{$urandom()}};
    acc = v && (m_st == 1);
    if (acc) begin
      w.ena  = 16'd1 << m_bank;
      w.addr = 9'(m_word);
      w.data = iData;
      exp_q.push_back(w);
      last_acc_edge = edge_idx + 1;
    end
    case (m_st)
      0: if (ld) begin m_st = 1; m_bank = 0; m_word = 0; m_done = 1'b0; end
      1: if (acc) begin
           if (m_bank == NB - 1 && m_word == WPB - 1) begin m_st = 2; m_gap = GAPC; end
           if (m_word == WPB - 1) begin m_word = 0; m_bank = m_bank + 1; end
           else m_word = m_word + 1;
         end
      2: if (m_gap == 0) m_st = 3; else m_gap = m_gap - 1;
      default: begin m_st = 0; m_done = 1'b1; end
    endcase
    @(posedge clk);
    edge_idx++;
    @(negedge clk);
    if (oStart) begin start_cnt++; start_edge = edge_idx; end
    n_cmp++;
    if ({oReady, oBusy, oStart, oDone} !== {m_st == 1, m_st != 0, m_st == 3, m_done}) begin
      n_bad++;
      $display("FAIL status edge=%0d got rdy/busy/start/done=%b want=%b", edge_idx,
               {oReady, oBusy, oStart, oDone}, {m_st == 1, m_st != 0, m_st == 3, m_done});
    end
    n_cmp++;
    if (o_ena != 16'd0) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_strobe edge=%0d got ena=%h want ena=0", edge_idx, o_ena);
      end else begin
        w = exp_q.pop_front();
        got = '{o_ena, o_addra, o_dia};
        if (got !== w || o_wea !== o_ena) begin
          n_bad++;
          $display("FAIL write edge=%0d got ena=%h wea=%h addr=%0d data=%h want ena=%h addr=%0d data=%h",
                   edge_idx, o_ena, o_wea, o_addra, o_dia, w.ena, w.addr, w.data);
        end
      end
    end else if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      n_bad++;
      $display("FAIL missing_strobe edge=%0d got ena=0 want ena=%h addr=%0d", edge_idx, w.ena, w.addr);
    end
  endtask

  task automatic run_to_idle(input int duty);
    int budget;
    budget = 0;
    while (m_st != 0 && budget < 20000) begin
      step(($urandom_range(99) < duty) ? 1'b1 : 1'b0, 1'b0);
      budget++;
    end
    n_cmp++;
    if (m_st != 0) begin
      n_bad++;
      $display("FAIL load_timeout got cycles=%0d want <20000", budget);
    end
  endtask

  task automatic check_load_end(input string name);
    n_cmp++;
    if (start_cnt != 1 || start_edge - last_acc_edge != GAPC + 1 || strobe_cnt != NB * WPB || oDone !== 1'b1) begin
      n_bad++;
      $display("FAIL %s got starts=%0d delay=%0d strobes=%0d done=%b want 1/%0d/%0d/1", name,
               start_cnt, start_edge - last_acc_edge, strobe_cnt, oDone, GAPC + 1, NB * WPB);
    end
  endtask

  task automatic begin_load();
    start_cnt = 0; strobe_cnt = 0;
    step(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rstn = 1'b0; iLoad = 1'b0; iValid = 1'b0; iData = '0;
    model_reset();
    #1;
    n_cmp++;
    if ({oReady, oBusy, oStart, oDone, o_ena, o_wea, o_addra, o_dia} !== '0) begin
      n_bad++;
      $display("FAIL reset got rdy=%b busy=%b ena=%h addr=%0d want all zero", oReady, oBusy, o_ena, o_addra);
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    step(1'b0, 1'b0);
  endtask

  task automatic test_full_load();
    begin_load();
    run_to_idle(100);
    check_load_end("full_load");
  endtask

  task automatic test_random_valid();
    begin_load();
    run_to_idle(50);
    check_load_end("random_valid");
  endtask

  task automatic test_bank_boundary();
    begin_load();
    while (!(m_bank == 3 && m_word == WPB - 1)) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    n_cmp++;
    if (o_ena !== 16'h0010 || o_addra !== 9'd0) begin
      n_bad++;
      $display("FAIL bank_boundary got ena=%h addr=%0d want ena=0010 addr=0", o_ena, o_addra);
    end
    run_to_idle(70);
    check_load_end("bank_boundary_load");
  endtask

  task automatic test_iload_ignored();
    logic gap_poked;
    gap_poked = 1'b0;
    begin_load();
    while (m_st != 0) begin
      if (m_st == 1 && m_bank * WPB + m_word == 500) step(1'b1, 1'b1);
      else if (m_st == 2 && !gap_poked) begin step(1'b0, 1'b1); gap_poked = 1'b1; end
      else step(1'b1, 1'b0);
    end
    check_load_end("iload_ignored");
  endtask

  task automatic test_mid_reset();
    begin_load();
    while (!(m_bank == 7 && m_word == 40)) step(1'b1, 1'b0);
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({oReady, oBusy, oStart, oDone, o_ena, o_wea, o_addra, o_dia} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset got rdy=%b busy=%b done=%b ena=%h addr=%0d want all zero",
               oReady, oBusy, oDone, o_ena, o_addra);
    end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    step(1'b0, 1'b0);
    begin_load();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    run_to_idle(100);
    check_load_end("restart_after_reset");
  endtask

  task automatic test_load_with_valid();
    start_cnt = 0; strobe_cnt = 0;
    step(1'b1, 1'b1);
    n_cmp++;
    if (o_ena !== 16'd0) begin
      n_bad++;
      $display("FAIL load_with_valid got ena=%h want 0", o_ena);
    end
    step(1'b1, 1'b0);
    n_cmp++;
    if (o_ena !== 16'h0001 || o_addra !== 9'd0) begin
      n_bad++;
      $display("FAIL first_strobe got ena=%h addr=%0d want ena=0001 addr=0", o_ena, o_addra);
    end
    run_to_idle(100);
    check_load_end("load_with_valid");
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_random_valid();
    test_bank_boundary();
    test_iload_ignored();
    test_mid_reset();
    test_load_with_valid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
